// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_pkg
// Brief    : Shared encodings and the latched-transaction record for the
//            instruction/data SRAM-like bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    // Everything the bus side needs, captured at the moment a port is accepted.
    typedef struct packed {
        arb_owner_t  owner;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_txn_t;

endpackage
`default_nettype wire

// File: rtl/sram_like_arbiter_select.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_select
// Brief    : Combinational grant decision with data-port priority and an
//            anti-starvation override for the instruction port.
// Revision : 1.0  initial release
// ============================================================================
module sram_like_arbiter_select
    import sram_like_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             enable,
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_inst,
    output logic             grant_data,
    output logic [CNT_W-1:0] starve_cnt_nxt
);

    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

    logic w_force_inst;

    always_comb begin
        w_force_inst   = inst_req && (starve_cnt == C_STARVE_MAX);
        grant_data     = enable && data_req && !w_force_inst;
        grant_inst     = enable && inst_req && !grant_data;
        starve_cnt_nxt = starve_cnt;
        // The counter only tracks data wins that actually kept inst waiting.
        if (grant_inst) begin
            starve_cnt_nxt = '0;
        end else if (grant_data) begin
            if (!inst_req) begin
                starve_cnt_nxt = '0;
            end else if (starve_cnt != C_STARVE_MAX) begin
                starve_cnt_nxt = starve_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : Merges the core's SRAM-like instruction and data ports onto one
//            memory bus, one outstanding transaction at a time.
// Revision : 1.0  initial release
// ============================================================================
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_txn_t         r_txn;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_cnt_nxt;
    logic             w_idle;
    logic             w_grant_inst;
    logic             w_grant_data;
    logic             w_resp;
    logic [31:0]      r_inst_rdata;
    logic [31:0]      r_data_rdata;
    logic             r_inst_data_ok;
    logic             r_data_data_ok;

    // Gated by rst so no port sees an accept while reset is asserted.
    assign w_idle = (r_state == ARB_IDLE) && !rst;
    assign w_resp = (r_state == ARB_WAIT) && mem_rvalid;

    sram_like_arbiter_select #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_select (
        .enable         (w_idle),
        .inst_req       (inst_req),
        .data_req       (data_req),
        .starve_cnt     (r_starve_cnt),
        .grant_inst     (w_grant_inst),
        .grant_data     (w_grant_data),
        .starve_cnt_nxt (w_starve_cnt_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant_inst || w_grant_data) w_state_nxt = ARB_REQ;
            ARB_REQ:  if (mem_gnt)                      w_state_nxt = ARB_WAIT;
            ARB_WAIT: if (mem_rvalid)                   w_state_nxt = ARB_IDLE;
            default:                                    w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB_IDLE;
            r_txn          <= '0;
            r_starve_cnt   <= '0;
            r_inst_rdata   <= '0;
            r_data_rdata   <= '0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            if (w_grant_data) begin
                r_txn <= '{owner: OWN_DATA, wr: data_wr,
                           wstrb: (data_wr ? data_wstrb : 4'b0000),
                           addr: data_addr, wdata: data_wdata};
            end else if (w_grant_inst) begin
                r_txn <= '{owner: OWN_INST, wr: 1'b0, wstrb: 4'b0000,
                           addr: inst_addr, wdata: 32'h0};
            end
            r_inst_data_ok <= w_resp && (r_txn.owner == OWN_INST);
            r_data_data_ok <= w_resp && (r_txn.owner == OWN_DATA);
            // Write acks leave the read-data holding registers untouched.
            if (w_resp && !r_txn.wr) begin
                if (r_txn.owner == OWN_INST) r_inst_rdata <= mem_rdata;
                else                         r_data_rdata <= mem_rdata;
            end
        end
    end

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;
    assign inst_data_ok = r_inst_data_ok;
    assign data_data_ok = r_data_data_ok;
    assign mem_req      = (r_state == ARB_REQ);
    assign mem_wr       = r_txn.wr;
    assign mem_wstrb    = r_txn.wstrb;
    assign mem_addr     = r_txn.addr;
    assign mem_wdata    = r_txn.wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Brief    : Self-checking bench: vector table of single transactions plus
//            hand sequences for contention, starvation and mid-flight reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_like_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    sram_like_arbiter #(
        .STARVE_MAX (4),
        .CNT_W      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        port;      // 0 = inst, 1 = data
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;     // value the bus returns
        int          gnt_dly;
        int          rv_dly;
        logic        exp_wr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } sb_t;

    sb_t         sb[$];
    vec_t        vecs[5];
    int          checks       = 0;
    int          failures     = 0;
    logic [31:0] m_inst_rdata = 32'h0;
    logic [31:0] m_data_rdata = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle and retire any completion against the scoreboard.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (inst_data_ok || data_data_ok) begin
            if (sb.size() == 0) begin
                chk("unexpected_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("data_ok_port", {inst_data_ok, data_data_ok}, e.port ? 2'b01 : 2'b10);
                chk("rdata", e.port ? data_rdata : inst_rdata, e.rdata);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {mem_req, mem_wr, mem_wstrb, inst_data_ok, data_data_ok,
                            inst_addr_ok, data_addr_ok}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_inst_rdata"}, inst_rdata, 0);
        chk({tag, "_data_rdata"}, data_rdata, 0);
    endtask

    // Called one cycle after accept (state REQ); returns in the following IDLE cycle.
    task automatic serve(input logic port, input logic wr, input logic [31:0] ea,
                         input logic ewr, input logic [3:0] ews, input logic [31:0] ewd,
                         input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                         input bit poke);
        sb_t e;
        for (int i = 0; i <= gnt_dly; i++) begin
            if (i == gnt_dly) begin
                mem_gnt = 1'b1;
                if (poke) begin
                    inst_req = 1'b0;
                    data_req = 1'b0;
                end
            end else if (poke) begin
                inst_req   = 1'b1;
                data_req   = 1'b1;
                inst_addr  = ~ea;
                data_addr  = ~ea;
                data_wdata = ~ewd;
                data_wr    = ~ewr;
                data_wstrb = ~ews;
            end
            #1;
            chk("mem_req_held", mem_req, 1);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wr", mem_wr, ewr);
            chk("mem_wstrb", mem_wstrb, ews);
            chk("mem_wdata", mem_wdata, ewd);
            chk("addr_ok_in_req", {inst_addr_ok, data_addr_ok}, 0);
            tick();
        end
        mem_gnt = 1'b0;
        for (int j = 0; j <= rv_dly; j++) begin
            if (j == rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                if (!wr) begin
                    if (port) m_data_rdata = rdata;
                    else      m_inst_rdata = rdata;
                end
                e.port  = port;
                e.rdata = port ? m_data_rdata : m_inst_rdata;
                sb.push_back(e);
            end else begin
                mem_rdata = $urandom;
            end
            #1;
            chk("mem_req_in_wait", mem_req, 0);
            chk("addr_ok_in_wait", {inst_addr_ok, data_addr_ok}, 0);
            tick();
        end
        mem_rvalid = 1'b0;
        chk("data_ok_seen", sb.size(), 0);
    endtask

    task automatic do_vec(input vec_t v);
        if (v.port) begin
            data_req   = 1'b1;
            data_wr    = v.wr;
            data_addr  = v.addr;
            data_wdata = v.wdata;
            data_wstrb = v.wstrb;
        end else begin
            inst_req  = 1'b1;
            inst_addr = v.addr;
        end
        #1;
        chk({v.name, "_addr_ok"}, {inst_addr_ok, data_addr_ok}, v.port ? 2'b01 : 2'b10);
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
        serve(v.port, v.wr, v.addr, v.exp_wr, v.exp_wstrb, v.exp_wdata,
              v.rdata, v.gnt_dly, v.rv_dly, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d;
        vecs[0] = '{"inst_boot",  1'b0, 1'b0, 32'hBFC0_0000, 32'h0,         4'h0,    32'h3C1D_0001, 1, 3, 1'b0, 4'h0,    32'h0};
        vecs[1] = '{"data_read",  1'b1, 1'b0, 32'h8000_0004, 32'h0,         4'hF,    32'hAABB_CCDD, 0, 1, 1'b0, 4'h0,    32'h0};
        vecs[2] = '{"data_write", 1'b1, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 32'hDEAD_BEEF, 0, 2, 1'b1, 4'b0011, 32'h1234_5678};
        vecs[3] = '{"gnt_stall",  1'b1, 1'b0, 32'h8000_0020, 32'h0,         4'h0,    32'h1122_3344, 5, 0, 1'b0, 4'h0,    32'h0};
        vecs[4] = '{"inst_read2", 1'b0, 1'b0, 32'hBFC0_0004, 32'h0,         4'h0,    32'h2408_0005, 2, 1, 1'b0, 4'h0,    32'h0};

        rst = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
        data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        foreach (vecs[k]) do_vec(vecs[k]);

        // Simultaneous requests: data wins, inst accepted alongside data_ok.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0004;
        data_wdata = 32'h0; data_wstrb = 4'h0;
        #1;
        chk("both_req_data_first", {inst_addr_ok, data_addr_ok}, 2'b01);
        tick();
        data_req = 1'b0;
        serve(1'b1, 1'b0, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 32'h0BAD_F00D, 1, 1, 1'b0);
        #1;
        chk("inst_after_data", {inst_addr_ok, data_addr_ok}, 2'b10);
        tick();
        inst_req = 1'b0;
        serve(1'b0, 1'b0, 32'hBFC0_0008, 1'b0, 4'h0, 32'h0, 32'h0000_0013, 0, 0, 1'b0);

        // Both held high: four data grants, then one forced inst grant, repeating.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_wdata = 32'h0;
        for (int k = 0; k < 10; k++) begin
            data_addr = 32'h8000_0100 + 32'(k * 4);
            exp_d = ((k % 5) != 4);
            #1;
            chk($sformatf("starve_grant%0d", k), {inst_addr_ok, data_addr_ok},
                exp_d ? 2'b01 : 2'b10);
            tick();
            serve(exp_d, 1'b0, exp_d ? data_addr : inst_addr, 1'b0, 4'h0, 32'h0,
                  32'h5000_0000 + 32'(k), 0, 0, 1'b0);
        end
        inst_req = 1'b0;
        data_req = 1'b0;

        // Reset while waiting for the response; the late rvalid must be ignored.
        inst_req = 1'b1; inst_addr = 32'h8000_1000;
        #1;
        chk("rst_seq_accept", {inst_addr_ok, data_addr_ok}, 2'b10);
        tick();
        inst_req = 1'b0;
        mem_gnt  = 1'b1;
        #1;
        chk("rst_seq_mem_req", mem_req, 1);
        tick();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        m_inst_rdata = 32'h0;
        m_data_rdata = 32'h0;
        check_all_zero("after_rst");
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_0000;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("stale_rvalid_no_req", mem_req, 0);
        tick();
        check_all_zero("stale_rvalid");
        do_vec(vecs[0]);

        repeat (2) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
